// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU operation sequencer: opcode width, opcode
// constants, sequencer state encoding, default legal-opcode mask and an
// opcode-legality helper.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_0 = 3'd0;
  localparam logic [OP_W-1:0] OP_1 = 3'd1;
  localparam logic [OP_W-1:0] OP_2 = 3'd2;
  localparam logic [OP_W-1:0] OP_3 = 3'd3;
  localparam logic [OP_W-1:0] OP_4 = 3'd4;
  localparam logic [OP_W-1:0] OP_5 = 3'd5;
  localparam logic [OP_W-1:0] OP_6 = 3'd6;
  localparam logic [OP_W-1:0] OP_7 = 3'd7;

  // Opcode 7 is reserved by default.
  localparam logic [(1<<OP_W)-1:0] OP_MASK_DEFAULT = 8'h7F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  // Returns the mask bit that enables opcode op.
  function automatic logic op_legal(input logic [(1<<OP_W)-1:0] mask,
                                    input logic [OP_W-1:0]      op);
    case (op)
      OP_0:    return mask[0];
      OP_1:    return mask[1];
      OP_2:    return mask[2];
      OP_3:    return mask[3];
      OP_4:    return mask[4];
      OP_5:    return mask[5];
      OP_6:    return mask[6];
      OP_7:    return mask[7];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/op_settle_timer.sv
// -----------------------------------------------------------------------------
// op_settle_timer
// Counts the cycles the ALU operands have been held stable and pulses done_o
// on the last settle cycle.
//
// Ports:
//   clk_i    rising-edge clock
//   reset_i  synchronous active-high reset (counter -> 0)
//   load_i   clear the counter (issued when a legal request is accepted)
//   en_i     count enable (high while settling)
//   done_o   combinational: en_i and counter == SETTLE_CYCLES-1
// -----------------------------------------------------------------------------
module op_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("op_settle_timer: SETTLE_CYCLES must be >= 1");
  end

  localparam int              CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  assign done_o = en_i && (cnt_q == LAST);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge value of every other register, as real flops do.
  always_ff @(posedge clk_i) begin
    if (reset_i || load_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      // Wrap to zero on the last cycle so the count never passes LAST.
      cnt_q <= done_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
// Accepts one ALU request at a time, drives the registered opcode/operands to
// the decoder and ALU, holds them for SETTLE_CYCLES, captures the ALU result
// and offers it downstream. Requests with an opcode cleared in OP_MASK are
// completed immediately with out_err_o set and never reach the datapath.
//
// Ports:
//   clk_i, reset_i             clock, synchronous active-high reset
//   in_valid_i / in_ready_o    request handshake
//   in_op_i, in_a_i, in_b_i    request opcode and operands
//   operation_o, alu_a_o/b_o   registered opcode/operands to decoder/ALU
//   alu_result_i               combinational ALU result
//   out_valid_o / out_ready_i  result handshake
//   out_result_o, out_op_o     captured result and its opcode
//   out_err_o                  completed request had an illegal opcode
//   busy_o                     sequencer not idle
//   op_count_o                 completed output handshakes (wraps)
// -----------------------------------------------------------------------------
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int                     WIDTH         = 8,
  parameter int                     SETTLE_CYCLES = 2,
  parameter logic [(1<<OP_W)-1:0]   OP_MASK       = OP_MASK_DEFAULT
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [OP_W-1:0]  in_op_i,
  input  logic [WIDTH-1:0] in_a_i,
  input  logic [WIDTH-1:0] in_b_i,
  output logic [OP_W-1:0]  operation_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  input  logic [WIDTH-1:0] alu_result_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_result_o,
  output logic [OP_W-1:0]  out_op_o,
  output logic             out_err_o,
  output logic             busy_o,
  output logic [15:0]      op_count_o
);

  state_e           state_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             out_valid_q;
  logic             out_err_q;
  logic [OP_W-1:0]  operation_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [WIDTH-1:0] out_result_q;
  logic [OP_W-1:0]  out_op_q;
  logic [15:0]      op_count_q;

  logic accept;
  logic accept_legal;
  logic settle_done;

  // in_ready_q is high exactly in IDLE, so it doubles as the accept qualifier.
  assign accept       = in_valid_i && in_ready_q;
  assign accept_legal = accept && op_legal(OP_MASK, in_op_i);

  op_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (accept_legal),
    .en_i    (state_q == SETTLE),
    .done_o  (settle_done)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_err_q    <= 1'b0;
      operation_q  <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      out_result_q <= '0;
      out_op_q     <= '0;
      op_count_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (accept_legal) begin
              operation_q <= in_op_i;
              alu_a_q     <= in_a_i;
              alu_b_q     <= in_b_i;
              state_q     <= SETTLE;
            end else begin
              // Datapath registers keep the last issued request.
              out_result_q <= '0;
              out_op_q     <= in_op_i;
              out_err_q    <= 1'b1;
              out_valid_q  <= 1'b1;
              state_q      <= HOLD;
            end
          end
        end

        SETTLE: begin
          if (settle_done) begin
            out_result_q <= alu_result_i;
            out_op_q     <= operation_q;
            out_err_q    <= 1'b0;
            out_valid_q  <= 1'b1;
            state_q      <= HOLD;
          end
        end

        HOLD: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            op_count_q  <= op_count_q + 16'd1;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o   = in_ready_q;
  assign busy_o       = busy_q;
  assign out_valid_o  = out_valid_q;
  assign out_err_o    = out_err_q;
  assign operation_o  = operation_q;
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign out_result_o = out_result_q;
  assign out_op_o     = out_op_q;
  assign op_count_o   = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
// Directed bench for alu_op_sequencer (WIDTH=8, SETTLE_CYCLES=2, mask 8'h7F).
// The ALU is modelled as alu_a + alu_b + noise; noise perturbs the result
// while a completed result is being held.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [2:0] operation;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_result;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic [2:0] out_op;
  logic       out_err;
  logic       busy;
  logic [15:0] op_count;

  logic [7:0] noise;

  int n_checks = 0;
  int n_errors = 0;

  alu_op_sequencer #(
    .WIDTH         (8),
    .SETTLE_CYCLES (2),
    .OP_MASK       (8'h7F)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_op_i      (in_op),
    .in_a_i       (in_a),
    .in_b_i       (in_b),
    .operation_o  (operation),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_result_i (alu_result),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_result_o (out_result),
    .out_op_o     (out_op),
    .out_err_o    (out_err),
    .busy_o       (busy),
    .op_count_o   (op_count)
  );

  assign alu_result = alu_a + alu_b + noise;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Back-to-back stimulus table.
  logic [2:0] v_op [3];
  logic [7:0] v_a  [3];
  logic [7:0] v_b  [3];
  logic [7:0] v_exp[3];

  initial begin
    int acc_t[$];
    logic [7:0] exp_q[$];
    int k;
    int n_hs;

    v_op[0] = 3'd0; v_a[0] = 8'h13; v_b[0] = 8'h05; v_exp[0] = 8'h18;
    v_op[1] = 3'd1; v_a[1] = 8'hF0; v_b[1] = 8'h20; v_exp[1] = 8'h10;
    v_op[2] = 3'd4; v_a[2] = 8'h7F; v_b[2] = 8'h01; v_exp[2] = 8'h80;

    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    out_ready = 1'b0; noise = '0;

    // ---------------- Reset ----------------
    repeat (3) step();
    reset = 1'b0;
    step();
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_operation", operation, 0);
    check("rst_op_count",  op_count,  0);
    check("rst_busy",      busy,      0);
    check("rst_out_err",   out_err,   0);

    // ---------------- Legal op 2: 0x0F + 0x01 ----------------
    in_valid = 1'b1; in_op = 3'd2; in_a = 8'h0F; in_b = 8'h01;
    step();                                   // accepting edge
    in_valid = 1'b0; in_op = 3'd6; in_a = 8'h00; in_b = 8'h00;
    check("leg_busy",       busy,      1);
    check("leg_in_ready",   in_ready,  0);
    check("leg_operation0", operation, 2);
    check("leg_alu_a",      alu_a,     8'h0F);
    check("leg_alu_b",      alu_b,     8'h01);
    check("leg_valid_e0",   out_valid, 0);
    step();
    check("leg_operation1", operation, 2);
    check("leg_valid_e1",   out_valid, 0);
    step();
    check("leg_valid_e2",   out_valid, 1);
    check("leg_result",     out_result, 8'h10);
    check("leg_err",        out_err,   0);
    check("leg_out_op",     out_op,    2);

    // ---------------- Backpressure in HOLD ----------------
    for (int i = 0; i < 5; i++) begin
      noise = 8'(i + 1);
      in_valid = 1'b1; in_op = 3'd5; in_a = 8'hFF; in_b = 8'hFF;
      step();
      check("bp_result",   out_result, 8'h10);
      check("bp_out_op",   out_op,     2);
      check("bp_in_ready", in_ready,   0);
      check("bp_valid",    out_valid,  1);
      check("bp_operand",  alu_a,      8'h0F);
    end
    in_valid = 1'b0; noise = '0; out_ready = 1'b1;
    step();                                   // handshake edge
    out_ready = 1'b0;
    check("bp_hs_valid",    out_valid, 0);
    check("bp_hs_in_ready", in_ready,  1);
    check("bp_hs_busy",     busy,      0);
    check("bp_hs_count",    op_count,  1);
    step();
    check("bp_single_hs",   op_count,  1);

    // ---------------- Illegal op 7 ----------------
    in_valid = 1'b1; in_op = 3'd7; in_a = 8'hAA; in_b = 8'h55;
    step();
    in_valid = 1'b0;
    check("ill_valid",     out_valid,  1);
    check("ill_err",       out_err,    1);
    check("ill_result",    out_result, 0);
    check("ill_out_op",    out_op,     7);
    check("ill_operation", operation,  2);
    check("ill_alu_a",     alu_a,      8'h0F);
    check("ill_alu_b",     alu_b,      8'h01);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("ill_hs_valid", out_valid, 0);
    check("ill_hs_count", op_count,  2);

    // ---------------- Reset in 2nd SETTLE cycle ----------------
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 3'd1; in_a = 8'h03; in_b = 8'h04;
    step();                                   // accept
    in_valid = 1'b0;
    step();                                   // now in 2nd SETTLE cycle
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_valid_rst", out_valid, 0);
    check("mid_count_rst", op_count,  0);
    step();
    check("mid_in_ready",  in_ready,  1);
    check("mid_valid",     out_valid, 0);
    check("mid_operation", operation, 0);
    for (int i = 0; i < 3; i++) step();
    check("mid_no_hs",     op_count,  0);
    check("mid_idle_busy", busy,      0);

    // ---------------- Back-to-back with out_ready=1 ----------------
    k = 0; n_hs = 0;
    in_valid = 1'b1; in_op = v_op[0]; in_a = v_a[0]; in_b = v_b[0];
    for (int cyc = 0; cyc < 16; cyc++) begin
      logic acc;
      acc = in_valid && in_ready;
      if (acc) begin
        acc_t.push_back(cyc);
        exp_q.push_back(v_exp[k]);
      end
      if (out_valid && out_ready) begin
        n_hs++;
        if (exp_q.size() > 0) check("b2b_result", out_result, exp_q.pop_front());
        else                  check("b2b_unexpected_hs", 1, 0);
      end
      step();
      if (acc) begin
        k++;
        if (k < 3) begin
          in_op = v_op[k]; in_a = v_a[k]; in_b = v_b[k];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check("b2b_accepts",    acc_t.size(), 3);
    check("b2b_handshakes", n_hs, 3);
    if (acc_t.size() == 3) begin
      check("b2b_spacing01", acc_t[1] - acc_t[0], 4);
      check("b2b_spacing12", acc_t[2] - acc_t[1], 4);
    end
    check("b2b_count", op_count, 3);

    // ---------------- op_count wrap ----------------
    out_ready = 1'b0;
    force dut.op_count_q = 16'hFFFF;
    step();
    release dut.op_count_q;
    step();
    check("wrap_preload", op_count, 16'hFFFF);
    in_valid = 1'b1; in_op = 3'd7; in_a = 8'h00; in_b = 8'h00;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("wrap_zero", op_count, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
